// File: rtl/aes_shiftrows_pipe.sv
// -----------------------------------------------------------------------------
// aes_shiftrows_pipe
//   Registered, flow-controlled Rijndael ShiftRows / InvShiftRows stage sitting
//   between SubBytes and MixColumns. The direction is chosen per block, and any
//   legal Rijndael block width is supported (NB = 4, 6 or 8 columns). An output
//   register plus a one-entry skid register keep one block per cycle flowing
//   even when the downstream stage stalls.
//
// Parameters
//   NB        state columns (4, 6 or 8); W = 32*NB data bits
//
// Ports
//   i_clk     clock, all state on rising edge
//   i_rst     asynchronous active-high reset
//   i_clear   synchronous flush of buffered blocks (priority over transfers)
//   i_valid   input block valid
//   o_ready   stage can accept a block this cycle (registered)
//   i_mode    0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt)
//   i_data    input state, column-major, byte s[r][c] at W-1-8*(4c+r)
//   o_valid   output block valid
//   i_ready   downstream accepts output
//   o_mode    mode bit travelling with o_data
//   o_data    shifted state
// -----------------------------------------------------------------------------
module aes_shiftrows_pipe #(
  parameter  int NB = 4,
  localparam int W  = 32 * NB
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_mode,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_mode,
  output logic [W-1:0] o_data
);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
  end

  // ---------------------------------------------------------------------------
  // Shift network: pure wiring, both directions built, mode selects.
  // Row offsets are 0,1,2,3 except NB=8 where rows 2 and 3 shift by 3 and 4.
  // ---------------------------------------------------------------------------
  logic [W-1:0] enc_data;
  logic [W-1:0] dec_data;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SH    = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int SRC_E = (c + SH) % NB;
      localparam int SRC_D = (c + NB - SH) % NB;
      assign enc_data[W-1-8*(4*c+r) -: 8] = i_data[W-1-8*(4*SRC_E+r) -: 8];
      assign dec_data[W-1-8*(4*c+r) -: 8] = i_data[W-1-8*(4*SRC_D+r) -: 8];
    end
  end

  logic [W-1:0] shift_data;
  always_comb begin
    shift_data = i_mode ? dec_data : enc_data;
  end

  // ---------------------------------------------------------------------------
  // Output register (out_*) and skid register (skd_*)
  // ---------------------------------------------------------------------------
  logic         out_valid_q, out_valid_d;
  logic         out_mode_q,  out_mode_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic         skd_valid_q, skd_valid_d;
  logic         skd_mode_q,  skd_mode_d;
  logic [W-1:0] skd_data_q,  skd_data_d;
  logic         ready_q,     ready_d;

  logic in_xfer;
  logic out_free;

  always_comb begin
    in_xfer  = i_valid & ready_q;
    out_free = ~out_valid_q | i_ready;

    out_valid_d = out_valid_q;
    out_mode_d  = out_mode_q;
    out_data_d  = out_data_q;
    skd_valid_d = skd_valid_q;
    skd_mode_d  = skd_mode_q;
    skd_data_d  = skd_data_q;
    ready_d     = ready_q;

    if (i_clear) begin
      // Data registers keep their contents; only the valid bits are dropped.
      out_valid_d = 1'b0;
      skd_valid_d = 1'b0;
      ready_d     = 1'b1;
    end else if (skd_valid_q && out_free) begin
      // Skid drains first; ready_q was low so no input can arrive this edge.
      out_valid_d = 1'b1;
      out_mode_d  = skd_mode_q;
      out_data_d  = skd_data_q;
      skd_valid_d = 1'b0;
      ready_d     = 1'b1;
    end else if (in_xfer && out_free) begin
      out_valid_d = 1'b1;
      out_mode_d  = i_mode;
      out_data_d  = shift_data;
    end else if (in_xfer) begin
      // Output is stalled: park the new block and close the input.
      skd_valid_d = 1'b1;
      skd_mode_d  = i_mode;
      skd_data_d  = shift_data;
      ready_d     = 1'b0;
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_valid_q <= 1'b0;
      out_mode_q  <= 1'b0;
      out_data_q  <= '0;
      skd_valid_q <= 1'b0;
      skd_mode_q  <= 1'b0;
      skd_data_q  <= '0;
      ready_q     <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      out_mode_q  <= out_mode_d;
      out_data_q  <= out_data_d;
      skd_valid_q <= skd_valid_d;
      skd_mode_q  <= skd_mode_d;
      skd_data_q  <= skd_data_d;
      ready_q     <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = out_valid_q;
  assign o_mode  = out_mode_q;
  assign o_data  = out_data_q;

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
module tb_aes_shiftrows_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic         vld = 1'b0;
  logic         mode = 1'b0;
  logic         rdy = 1'b1;
  logic [255:0] din = '0;

  always #5 clk = ~clk;

  logic         o_valid4, o_ready4, o_mode4;
  logic [127:0] o_data4;
  logic         o_valid6, o_ready6, o_mode6;
  logic [191:0] o_data6;
  logic         o_valid8, o_ready8, o_mode8;
  logic [255:0] o_data8;

  logic         ce_valid, ce_ready, ce_mode;
  logic [127:0] ce_data;
  logic         cd_valid, cd_ready, cd_mode;
  logic [127:0] cd_data;

  aes_shiftrows_pipe #(.NB(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_valid(vld), .o_ready(o_ready4),
    .i_mode(mode), .i_data(din[127:0]), .o_valid(o_valid4), .i_ready(rdy),
    .o_mode(o_mode4), .o_data(o_data4));

  aes_shiftrows_pipe #(.NB(6)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_valid(vld), .o_ready(o_ready6),
    .i_mode(mode), .i_data(din[191:0]), .o_valid(o_valid6), .i_ready(rdy),
    .o_mode(o_mode6), .o_data(o_data6));

  aes_shiftrows_pipe #(.NB(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_valid(vld), .o_ready(o_ready8),
    .i_mode(mode), .i_data(din), .o_valid(o_valid8), .i_ready(rdy),
    .o_mode(o_mode8), .o_data(o_data8));

  // encrypt stage feeding a decrypt stage: the pair must be the identity
  aes_shiftrows_pipe #(.NB(4)) ce (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_valid(vld), .o_ready(ce_ready),
    .i_mode(1'b0), .i_data(din[127:0]), .o_valid(ce_valid), .i_ready(cd_ready),
    .o_mode(ce_mode), .o_data(ce_data));

  aes_shiftrows_pipe #(.NB(4)) cd (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_valid(ce_valid), .o_ready(cd_ready),
    .i_mode(1'b1), .i_data(ce_data), .o_valid(cd_valid), .i_ready(1'b1),
    .o_mode(cd_mode), .o_data(cd_data));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference ShiftRows: each row as a byte queue rotated by its offset.
  function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input logic inv);
    int          w;
    int          sh_tbl[4];
    logic [7:0]  row[$];
    logic [7:0]  b;
    logic [255:0] o;
    w = 32 * nb;
    o = '0;
    if (nb == 8) sh_tbl = '{0, 1, 3, 4};
    else         sh_tbl = '{0, 1, 2, 3};
    for (int r = 0; r < 4; r++) begin
      row.delete();
      for (int c = 0; c < nb; c++) row.push_back(d[w-1-8*(4*c+r) -: 8]);
      for (int k = 0; k < sh_tbl[r]; k++) begin
        if (!inv) begin b = row.pop_front(); row.push_back(b); end
        else      begin b = row.pop_back();  row.push_front(b); end
      end
      for (int c = 0; c < nb; c++) o[w-1-8*(4*c+r) -: 8] = row[c];
    end
    return o;
  endfunction

  function automatic logic [255:0] pat(input int nb);
    logic [255:0] p;
    p = '0;
    for (int i = 0; i < 4 * nb; i++) p[32*nb-1-8*i -: 8] = 8'(i);
    return p;
  endfunction

  // Transaction-level model: a FIFO of capacity 2 (output + skid).
  logic [255:0] mq_d[$];
  logic         mq_m[$];
  bit           m_acc = 1'b0;

  always @(posedge clk or posedge rst) begin
    int cnt;
    bit do_pop, do_push;
    if (rst) begin
      mq_d.delete(); mq_m.delete(); m_acc = 1'b0;
    end else begin
      cnt = mq_d.size();
      m_acc = 1'b0;
      if (clr) begin
        mq_d.delete(); mq_m.delete();
      end else begin
        do_pop  = (cnt > 0) && rdy;
        do_push = vld && (cnt < 2);
        if (do_pop) begin void'(mq_d.pop_front()); void'(mq_m.pop_front()); end
        if (do_push) begin mq_d.push_back(din); mq_m.push_back(mode); end
        m_acc = do_push;
      end
    end
  end

  task automatic cmp_dut(input string nm, input int nb, input logic v, input logic r,
                         input logic m, input logic [255:0] d);
    logic ev, er;
    ev = mq_d.size() > 0;
    er = mq_d.size() < 2;
    chk({nm, "_valid"}, v, ev);
    chk({nm, "_ready"}, r, er);
    if (ev) begin
      chk({nm, "_mode"}, m, mq_m[0]);
      chk({nm, "_data"}, d, ref_shift(mq_d[0], nb, mq_m[0]));
    end
  endtask

  always @(negedge clk) begin
    cmp_dut("nb4", 4, o_valid4, o_ready4, o_mode4, {128'h0, o_data4});
    cmp_dut("nb6", 6, o_valid6, o_ready6, o_mode6, {64'h0, o_data6});
    cmp_dut("nb8", 8, o_valid8, o_ready8, o_mode8, o_data8);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [255:0] d, input logic m, output int waited);
    vld = 1'b1; din = d; mode = m; waited = 0;
    do begin
      step();
      waited++;
    end while (!m_acc && waited < 50);
    if (!m_acc) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: block not accepted after %0d cycles", waited);
    end
    vld = 1'b0;
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [255:0] t;
  int           w;
  bit           rnd_done;

  initial begin
    // model pins
    chk("ref4_enc", ref_shift(pat(4), 4, 1'b0), {128'h0, 128'h00050a0f04090e03080d02070c01060b});
    chk("ref4_dec", ref_shift(pat(4), 4, 1'b1), {128'h0, 128'h000d0a0704010e0b0805020f0c090603});
    t = ref_shift(pat(8), 8, 1'b0); chk("ref8_enc_col0", t[255:224], 32'h00050e13);
    t = ref_shift(pat(8), 8, 1'b1); chk("ref8_dec_col0", t[255:224], 32'h001d1613);
    t = ref_shift(pat(6), 6, 1'b0); chk("ref6_enc_col0", t[191:160], 32'h00050a0f);
    chk("ref6_enc_col5", t[31:0], 32'h1401060b);

    // reset
    #1 rst = 1'b1;
    step(); step();
    chk("rst_valid", o_valid4, 1'b0);
    chk("rst_ready", o_ready4, 1'b1);
    chk("rst_data", o_data4, 128'h0);
    chk("rst_mode", o_mode4, 1'b0);
    rst = 1'b0;
    step();

    // test 1/2: literal vectors, encrypt->decrypt identity
    rdy = 1'b1;
    push(pat(4), 1'b0, w);
    chk("t1_valid", o_valid4, 1'b1);
    chk("t1_data", o_data4, 128'h00050a0f04090e03080d02070c01060b);
    step();
    chk("t1_chain", cd_data, 128'h000102030405060708090a0b0c0d0e0f);
    push(pat(4), 1'b1, w);
    chk("t2_data", o_data4, 128'h000d0a0704010e0b0805020f0c090603);
    chk("t2_mode", o_mode4, 1'b1);
    step(); step();

    // test 3: stream 8 blocks with a 4-cycle downstream stall
    fork
      begin
        for (int k = 0; k < 8; k++) push(rnd256(), k[0], w);
      end
      begin
        rdy = 1'b1; step(); step();
        rdy = 1'b0; repeat (4) step();
        rdy = 1'b1;
      end
    join
    repeat (4) step();

    // test 4: alternating modes at full rate
    rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push(rnd256(), k[0], w);
      chk("t4_rate", w, 1);
    end
    repeat (3) step();

    // test 6: byte = index patterns, both modes, all widths
    for (int k = 0; k < 6; k++) begin
      push(pat(k < 2 ? 4 : (k < 4 ? 6 : 8)), k[0], w);
      if (k == 4) chk("t6_nb8_col0", o_data8[255:224], 32'h00050e13);
    end
    repeat (3) step();

    // test 5a: fill output + skid, then clear with a block offered
    rdy = 1'b0;
    push(rnd256(), 1'b1, w);
    push(rnd256(), 1'b0, w);
    chk("t5_full_ready", o_ready4, 1'b0);
    vld = 1'b1; din = rnd256(); clr = 1'b1;
    step();
    clr = 1'b0; vld = 1'b0;
    chk("t5_clr_valid", o_valid4, 1'b0);
    chk("t5_clr_ready", o_ready4, 1'b1);
    rdy = 1'b1; step(); step();

    // test 5b: asynchronous reset while full
    rdy = 1'b0;
    push({8{32'hdeadbeef}}, 1'b1, w);
    push({8{32'hcafef00d}}, 1'b1, w);
    #2 rst = 1'b1;
    #1;
    chk("t5_arst_valid", o_valid4, 1'b0);
    chk("t5_arst_data", o_data4, 128'h0);
    chk("t5_arst_mode", o_mode4, 1'b0);
    chk("t5_arst_ready", o_ready4, 1'b1);
    chk("t5_arst_data8", o_data8, 256'h0);
    step();
    rst = 1'b0;
    rdy = 1'b1;
    step();

    // random run: 1000 blocks, random gaps, random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          if ($urandom_range(0, 3) == 0) step();
          push(rnd256(), 1'($urandom_range(0, 1)), w);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          rdy = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    rdy = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
